// File: rtl/reset_sequencer.sv
// Power-up reset sequencer: releases SDRAM, then camera, then enables display after a settle time.
// Optional macro RST_SEQ_RETRY_EN turns a sticky ERROR into a bounded retry loop (3 retries, 4th error sticky).
module reset_sequencer #(
  parameter int TIMEOUT_CYC = 1000000,
  parameter int SETTLE_CYC  = 1000,
  parameter int CNT_W       = 20
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       sys_rst_n,
  input  logic       sdram_init_done,
  input  logic       cam_cfg_done,
  output logic       sdram_rst_n,
  output logic       cam_rst_n,
  output logic       vga_en,
  output logic       ready,
  output logic       timeout_err,
  output logic [2:0] seq_state
);

  typedef enum logic [2:0] {
    IDLE      = 3'd0,
    SDRAM_REL = 3'd1,
    CAM_REL   = 3'd2,
    SETTLE    = 3'd3,
    RUN       = 3'd4,
    ERROR     = 3'd5
  } state_t;

  localparam logic [CNT_W-1:0] TO_LAST = CNT_W'(TIMEOUT_CYC - 1);
  localparam logic [CNT_W-1:0] ST_LAST = CNT_W'(SETTLE_CYC - 1);
  localparam logic [CNT_W-1:0] CNT_ONE = CNT_W'(1);
`ifdef RST_SEQ_RETRY_EN
  localparam logic [CNT_W-1:0] ERR_LAST = CNT_W'(15);
  logic [1:0] r_retry;
  logic       r_sticky;
`endif

  logic             r_sync1;
  logic             r_sync2;
  logic             w_s_rel;
  state_t           r_state;
  state_t           w_next;
  logic [CNT_W-1:0] r_timer;
  logic             r_sdram_rst_n;
  logic             r_cam_rst_n;
  logic             r_run;
  logic             r_err;

  assign w_s_rel = r_sync2;

  always_comb begin
    w_next = r_state;
    case (r_state)
      IDLE:      if (w_s_rel) w_next = SDRAM_REL;
      SDRAM_REL: begin
        // A done arriving on the last timeout cycle still counts as success.
        if (sdram_init_done)         w_next = CAM_REL;
        else if (r_timer == TO_LAST) w_next = ERROR;
      end
      CAM_REL: begin
        if (cam_cfg_done)            w_next = SETTLE;
        else if (r_timer == TO_LAST) w_next = ERROR;
      end
      SETTLE:    if (r_timer == ST_LAST) w_next = RUN;
      RUN:       w_next = RUN;
      ERROR: begin
`ifdef RST_SEQ_RETRY_EN
        if (!r_sticky && r_timer == ERR_LAST) w_next = IDLE;
        else                                   w_next = ERROR;
`else
        w_next = ERROR;
`endif
      end
      default:   w_next = IDLE;
    endcase
    if (!w_s_rel && r_state != IDLE) w_next = IDLE;
  end

  // Outputs are registered from the next state so they always match seq_state.
  always_ff @(posedge clk) begin
    if (rst) begin
      r_sync1       <= 1'b0;
      r_sync2       <= 1'b0;
      r_state       <= IDLE;
      r_timer       <= '0;
      r_sdram_rst_n <= 1'b0;
      r_cam_rst_n   <= 1'b0;
      r_run         <= 1'b0;
      r_err         <= 1'b0;
`ifdef RST_SEQ_RETRY_EN
      r_retry       <= 2'd0;
      r_sticky      <= 1'b0;
`endif
    end else begin
      r_sync1 <= sys_rst_n;
      r_sync2 <= r_sync1;
      r_state <= w_next;
      if (w_next != r_state)  r_timer <= '0;
      else if (r_timer != '1) r_timer <= r_timer + CNT_ONE;
      r_sdram_rst_n <= (w_next inside {SDRAM_REL, CAM_REL, SETTLE, RUN});
      r_cam_rst_n   <= (w_next inside {CAM_REL, SETTLE, RUN});
      r_run         <= (w_next == RUN);
      r_err         <= (w_next == ERROR);
`ifdef RST_SEQ_RETRY_EN
      if (w_next == RUN && r_state != RUN) begin
        r_retry  <= 2'd0;
        r_sticky <= 1'b0;
      end else if (w_next == ERROR && r_state != ERROR) begin
        if (r_retry == 2'd3) r_sticky <= 1'b1;
        else                 r_retry  <= r_retry + 2'd1;
      end
`endif
    end
  end

  assign sdram_rst_n = r_sdram_rst_n;
  assign cam_rst_n   = r_cam_rst_n;
  assign vga_en      = r_run;
  assign ready       = r_run;
  assign timeout_err = r_err;
  assign seq_state   = r_state;

endmodule

// File: tb/tb_reset_sequencer.sv
// Bench for reset_sequencer: nominal vector table, hand-written corner sequences,
// then randomized stimulus against a cycle-level reference model (honours RST_SEQ_RETRY_EN).
module tb_reset_sequencer;

  localparam int TO = 100;
  localparam int ST = 10;

  logic       clk = 1'b0;
  logic       rst = 1'b1;
  logic       sys_rst_n = 1'b0;
  logic       sdram_init_done = 1'b0;
  logic       cam_cfg_done = 1'b0;
  logic       sdram_rst_n, cam_rst_n, vga_en, ready, timeout_err;
  logic [2:0] seq_state;
  logic [4:0] w_outs;

  int checks = 0;
  int errors = 0;

  reset_sequencer #(.TIMEOUT_CYC(TO), .SETTLE_CYC(ST), .CNT_W(8)) dut (
    .clk(clk), .rst(rst), .sys_rst_n(sys_rst_n),
    .sdram_init_done(sdram_init_done), .cam_cfg_done(cam_cfg_done),
    .sdram_rst_n(sdram_rst_n), .cam_rst_n(cam_rst_n), .vga_en(vga_en),
    .ready(ready), .timeout_err(timeout_err), .seq_state(seq_state)
  );

  always #5 clk = ~clk;

  assign w_outs = {sdram_rst_n, cam_rst_n, vga_en, ready, timeout_err};

  // Reference model: phase number, cycles spent in that phase, error entries since last RUN.
  int m_phase = 0;
  int m_age = 0;
  int m_err_entries = 0;
  bit srel_q[$] = '{1'b0, 1'b0};

  function automatic logic [4:0] exp_outs(input int p);
    return {(p >= 1 && p <= 4), (p >= 2 && p <= 4), (p == 4), (p == 4), (p == 5)};
  endfunction

  task automatic model_edge();
    bit s;
    int np;
    if (rst) begin
      srel_q = '{1'b0, 1'b0};
      m_phase = 0;
      m_age = 0;
      m_err_entries = 0;
    end else begin
      s = srel_q.pop_front();
      srel_q.push_back(sys_rst_n);
      np = m_phase;
      if (m_phase != 0 && !s) np = 0;
      else begin
        case (m_phase)
          0: if (s) np = 1;
          1: if (sdram_init_done) np = 2; else if (m_age == TO - 1) np = 5;
          2: if (cam_cfg_done) np = 3; else if (m_age == TO - 1) np = 5;
          3: if (m_age == ST - 1) np = 4;
`ifdef RST_SEQ_RETRY_EN
          5: if (m_err_entries < 4 && m_age == 15) np = 0;
`endif
          default: ;
        endcase
      end
      if (np == 5 && m_phase != 5) m_err_entries++;
      if (np == 4 && m_phase != 4) m_err_entries = 0;
      m_age = (np != m_phase) ? 0 : m_age + 1;
      m_phase = np;
    end
  endtask

  task automatic step(input int n);
    for (int i = 0; i < n; i++) begin
      model_edge();
      @(posedge clk);
      #1;
    end
  endtask

  task automatic chk(input string name, input logic [2:0] st, input logic [4:0] o);
    checks++;
    if (seq_state !== st) begin
      errors++;
      $display("FAIL %s seq_state got %0d want %0d", name, seq_state, st);
    end
    checks++;
    if (w_outs !== o) begin
      errors++;
      $display("FAIL %s outs got %b want %b", name, w_outs, o);
    end
  endtask

  task automatic restart();
    rst = 1'b1; sys_rst_n = 1'b0; sdram_init_done = 1'b0; cam_cfg_done = 1'b0;
    step(1);
    rst = 1'b0;
  endtask

  typedef struct {
    logic       srn;
    logic       sd;
    logic       cd;
    int         n;
    logic [2:0] st;
    logic [4:0] o;
  } vec_t;

  vec_t tbl[11];
  int   shown = 0;

  initial begin
    tbl[0]  = '{1'b1, 1'b0, 1'b0, 2,  3'd0, 5'b00000};
    tbl[1]  = '{1'b1, 1'b0, 1'b0, 1,  3'd1, 5'b10000};
    tbl[2]  = '{1'b1, 1'b0, 1'b0, 17, 3'd1, 5'b10000};
    tbl[3]  = '{1'b1, 1'b1, 1'b0, 1,  3'd2, 5'b11000};
    tbl[4]  = '{1'b1, 1'b1, 1'b0, 19, 3'd2, 5'b11000};
    tbl[5]  = '{1'b1, 1'b1, 1'b1, 1,  3'd3, 5'b11000};
    tbl[6]  = '{1'b1, 1'b1, 1'b1, 9,  3'd3, 5'b11000};
    tbl[7]  = '{1'b1, 1'b1, 1'b1, 1,  3'd4, 5'b11110};
    tbl[8]  = '{1'b1, 1'b0, 1'b0, 5,  3'd4, 5'b11110};
    tbl[9]  = '{1'b0, 1'b0, 1'b0, 2,  3'd4, 5'b11110};
    tbl[10] = '{1'b0, 1'b0, 1'b0, 1,  3'd0, 5'b00000};

    // Reset holds everything low even with sys_rst_n and done inputs high.
    rst = 1'b1; sys_rst_n = 1'b1; sdram_init_done = 1'b1; cam_cfg_done = 1'b1;
    step(3);
    chk("reset", 3'd0, 5'b00000);
    sys_rst_n = 1'b0; sdram_init_done = 1'b0; cam_cfg_done = 1'b0;
    step(1);
    rst = 1'b0;

    // Nominal sequence and mid-RUN drop: row r applied after edge 0 + previous rows.
    for (int r = 0; r < 11; r++) begin
      sys_rst_n = tbl[r].srn; sdram_init_done = tbl[r].sd; cam_cfg_done = tbl[r].cd;
      step(tbl[r].n);
      chk($sformatf("row%0d", r), tbl[r].st, tbl[r].o);
    end

    // Timeout in SDRAM_REL, then retry behaviour or sticky ERROR.
    restart();
    sys_rst_n = 1'b1;
    step(3);  chk("to_entry", 3'd1, exp_outs(1));
    step(99); chk("to_last",  3'd1, exp_outs(1));
    step(1);  chk("to_err",   3'd5, exp_outs(5));
`ifdef RST_SEQ_RETRY_EN
    for (int k = 0; k < 3; k++) begin
      step(15); chk($sformatf("retry%0d_hold", k), 3'd5, exp_outs(5));
      step(1);  chk($sformatf("retry%0d_idle", k), 3'd0, exp_outs(0));
      step(1);  chk($sformatf("retry%0d_sdram", k), 3'd1, exp_outs(1));
      step(99); chk($sformatf("retry%0d_wait", k), 3'd1, exp_outs(1));
      step(1);  chk($sformatf("retry%0d_err", k), 3'd5, exp_outs(5));
    end
`endif
    step(40); chk("err_sticky", 3'd5, exp_outs(5));
    rst = 1'b1;
    step(1);  chk("rst_in_err", 3'd0, exp_outs(0));
    rst = 1'b0;

    // Done rises exactly on the final timeout cycle: success wins.
    restart();
    sys_rst_n = 1'b1;
    step(3);  chk("sim_entry", 3'd1, exp_outs(1));
    step(99);
    sdram_init_done = 1'b1;
    step(1);  chk("simultaneous", 3'd2, exp_outs(2));

    // Dones already high: one cycle per wait state, cam done ignored early; then drop in SETTLE.
    restart();
    sys_rst_n = 1'b1; sdram_init_done = 1'b1; cam_cfg_done = 1'b1;
    step(3);  chk("pre_sdram", 3'd1, exp_outs(1));
    step(1);  chk("pre_cam",   3'd2, exp_outs(2));
    step(1);  chk("pre_settle", 3'd3, exp_outs(3));
    step(3);  chk("settle_mid", 3'd3, exp_outs(3));
    sys_rst_n = 1'b0;
    step(2);  chk("drop_sync", 3'd3, exp_outs(3));
    step(1);  chk("drop_idle", 3'd0, exp_outs(0));
    sys_rst_n = 1'b1;
    step(3);  chk("rerel_sdram", 3'd1, exp_outs(1));
    step(1);  chk("rerel_cam",   3'd2, exp_outs(2));
    step(1);  chk("rerel_settle", 3'd3, exp_outs(3));
    step(9);  chk("rerel_settle_end", 3'd3, exp_outs(3));
    step(1);  chk("rerel_run", 3'd4, exp_outs(4));
    rst = 1'b1;
    step(1);  chk("rst_in_run", 3'd0, exp_outs(0));
    rst = 1'b0;
    step(2);  chk("rst_sync_clr", 3'd0, exp_outs(0));
    step(1);  chk("rst_rerel", 3'd1, exp_outs(1));

    // Randomized stimulus against the reference model.
    restart();
    sys_rst_n = 1'b1;
    for (int c = 0; c < 6000; c++) begin
      if (sys_rst_n && $urandom_range(0, 399) == 0) sys_rst_n = 1'b0;
      else if (!sys_rst_n && $urandom_range(0, 7) == 0) sys_rst_n = 1'b1;
      if ($urandom_range(0, 44) == 0) sdram_init_done = ~sdram_init_done;
      if ($urandom_range(0, 44) == 0) cam_cfg_done = ~cam_cfg_done;
      rst = ($urandom_range(0, 1499) == 0);
      step(1);
      checks++;
      if (seq_state !== 3'(m_phase) || w_outs !== exp_outs(m_phase)) begin
        errors++;
        if (shown < 20) begin
          shown++;
          $display("FAIL rand cycle %0d state/outs got %0d/%b want %0d/%b",
                   c, seq_state, w_outs, m_phase, exp_outs(m_phase));
        end
      end
    end

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

// File: doc/reset_sequencer.md
RESET_SEQUENCER -- requirements
Module: reset_sequencer

Interface
REQ-001 SHALL provide parameter TIMEOUT_CYC, default 1000000: maximum cycles to wait for each init-done input.
REQ-002 SHALL provide parameter SETTLE_CYC, default 1000: cycles between camera config done and ready.
REQ-003 SHALL provide parameter CNT_W, default 20: width of the shared cycle timer; SHALL hold max(TIMEOUT_CYC, SETTLE_CYC).
REQ-004 SHALL have port clk  input  1  the single clock for all logic.
REQ-005 SHALL have port rst  input  1  reset, synchronous to clk, active-high.
REQ-006 SHALL have port sys_rst_n  input  1  delayed system reset release from the system controller; asynchronous, level-sensitive.
REQ-007 SHALL have port sdram_init_done  input  1  SDRAM controller init complete, level.
REQ-008 SHALL have port cam_cfg_done  input  1  camera register configuration complete, level.
REQ-009 SHALL have port sdram_rst_n  output  1  SDRAM controller reset, low = held in reset.
REQ-010 SHALL have port cam_rst_n  output  1  camera config and capture reset, low = held in reset.
REQ-011 SHALL have port vga_en  output  1  display pipeline enable.
REQ-012 SHALL have port ready  output  1  whole system up.
REQ-013 SHALL have port timeout_err  output  1  a stage timed out.
REQ-014 SHALL have port seq_state  output  3  current state encoding.

Function
REQ-015 SHALL pass sys_rst_n through a 2-flop synchronizer to form s_rel; all other logic SHALL use s_rel only.
REQ-016 SHALL implement states IDLE=0, SDRAM_REL=1, CAM_REL=2, SETTLE=3, RUN=4, ERROR=5, driven onto seq_state.
REQ-017 Outputs SHALL be Moore decodes of the state register: sdram_rst_n=1 in SDRAM_REL, CAM_REL, SETTLE and RUN; cam_rst_n=1 in CAM_REL, SETTLE and RUN; vga_en=ready=1 in RUN only; timeout_err=1 in ERROR only.
REQ-018 IDLE -> SDRAM_REL on the first cycle s_rel=1; sys_rst_n rising at edge N SHALL give sdram_rst_n=1 after edge N+3.
REQ-019 SDRAM_REL -> CAM_REL when sdram_init_done=1; CAM_REL -> SETTLE when cam_cfg_done=1.
REQ-020 SETTLE -> RUN when timer = SETTLE_CYC-1; RUN is terminal while s_rel=1.
REQ-021 The timer SHALL clear to 0 on every state change and increment by 1 each cycle otherwise, saturating at all-ones.
REQ-022 In SDRAM_REL or CAM_REL, timer = TIMEOUT_CYC-1 with done=0 SHALL give -> ERROR; done=1 on the same cycle SHALL win and give normal advance.
REQ-023 s_rel=0 in any state other than IDLE SHALL force -> IDLE on the next edge, overriding every other transition.
REQ-024 Done inputs SHALL be ignored outside their own wait state; a done already high on entry SHALL advance after exactly one cycle in that state.

Reset
REQ-025 rst=1 at a clk edge SHALL set state=IDLE, timer=0, and both synchronizer flops=0, giving sdram_rst_n=0, cam_rst_n=0, vga_en=0, ready=0, timeout_err=0, seq_state=0.
REQ-026 rst SHALL take priority over every transition, including mid-sequence and in ERROR.

Configuration
REQ-027 Macro RST_SEQ_RETRY_EN SHALL select ERROR behaviour.
REQ-028 With RST_SEQ_RETRY_EN defined: ERROR SHALL last 16 cycles and then go to IDLE; a 2-bit retry counter SHALL increment on each ERROR entry; the 4th ERROR entry SHALL be sticky; the counter SHALL clear on rst or on entry to RUN.
REQ-029 With RST_SEQ_RETRY_EN undefined: ERROR SHALL be sticky until rst=1 or s_rel=0, and no retry counter SHALL exist.

Verification (TIMEOUT_CYC=100, SETTLE_CYC=10)
REQ-030 Nominal: rst pulse, then sys_rst_n=1 at edge 0, sdram_init_done=1 at edge 20, cam_cfg_done=1 at edge 40 -> sdram_rst_n=1 from edge 3, cam_rst_n=1 from edge 21, ready=1 from edge 51.
REQ-031 Timeout: sdram_init_done held 0 -> seq_state=5 and timeout_err=1 exactly 100 cycles after SDRAM_REL entry, with sdram_rst_n=0.
REQ-032 Simultaneous: sdram_init_done rises on the cycle timer=99 -> CAM_REL entered, timeout_err stays 0.
REQ-033 Mid-operation drop: sys_rst_n=0 while in SETTLE -> seq_state=0 and all outputs 0 within 3 cycles; re-release -> full sequence repeats.
REQ-034 With RST_SEQ_RETRY_EN and sdram_init_done stuck 0 -> three retries with 16-cycle ERROR each, then ERROR held permanently; without the macro -> ERROR held after the first timeout.
